// File: rtl/if_neuron_ctrl_if.sv
// Bundle of the neuron controller's handshake and adder signals.
//   Event side : in_valid, weight[9:0], leak_tick -> controller; in_ready <- controller
//   Adder side : acc_a[9:0], acc_b[9:0], acc_cin <- controller; sum_in[9:0], cout_in -> controller
//   State out  : vmem[9:0], spike <- controller
// slave is the controller's view; master is the view of whatever surrounds it
// (event source plus the external 10-bit adder).
interface if_neuron_ctrl_if;
  logic       in_valid;
  logic [9:0] weight;
  logic       in_ready;
  logic       leak_tick;
  logic [9:0] acc_a;
  logic [9:0] acc_b;
  logic       acc_cin;
  logic [9:0] sum_in;
  logic       cout_in;
  logic [9:0] vmem;
  logic       spike;

  modport slave (
    input  in_valid, weight, leak_tick, sum_in, cout_in,
    output in_ready, acc_a, acc_b, acc_cin, vmem, spike
  );

  modport master (
    output in_valid, weight, leak_tick, sum_in, cout_in,
    input  in_ready, acc_a, acc_b, acc_cin, vmem, spike
  );
endinterface

// File: rtl/if_neuron_ctrl.sv
// Integrate-and-fire neuron controller driving an external 10-bit adder.
// Synaptic events add their weight to the membrane value, leak requests
// subtract LEAK from it. Operands are held on the adder for SETTLE_CYC
// cycles before the sum is captured. Additions saturate at 1023,
// subtractions clamp at 0. An addition whose result reaches THRESH emits a
// one-cycle spike, clears the membrane and enters a REFRAC_CYC-cycle
// refractory period during which events and leaks are dropped.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - if_neuron_ctrl_if.slave (event handshake, adder operands/result,
//          vmem, spike)
module if_neuron_ctrl #(
  parameter int THRESH     = 512,
  parameter int SETTLE_CYC = 3,
  parameter int REFRAC_CYC = 4,
  parameter int LEAK       = 1
) (
  input  logic              clk,
  input  logic              rst,
  if_neuron_ctrl_if.slave   bus
);

  localparam int DATA_W = 10;
  localparam logic [DATA_W-1:0] THRESH_V  = DATA_W'(THRESH);
  localparam logic [DATA_W-1:0] LEAK_V    = DATA_W'(LEAK);
  localparam logic [3:0]        SETTLE_LD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0]        REFRAC_LD = 4'(REFRAC_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, REFRAC} state_t;

  state_t            state;
  logic              leak_pend;
  logic              op_sub;
  logic [3:0]        cnt;
  logic [3:0]        rcnt;
  logic [DATA_W-1:0] add_res;
  logic [DATA_W-1:0] sub_res;

  // Carry-out of an add means the true result exceeded 10 bits.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] sum,
                                                input logic cout);
    return cout ? {DATA_W{1'b1}} : sum;
  endfunction

  // Subtraction is a + ~b + 1; a missing carry-out is a borrow.
  function automatic logic [DATA_W-1:0] clamp_sub(input logic [DATA_W-1:0] sum,
                                                  input logic cout);
    return cout ? sum : {DATA_W{1'b0}};
  endfunction

  always_comb begin
    add_res = sat_add(bus.sum_in, bus.cout_in);
    sub_res = clamp_sub(bus.sum_in, bus.cout_in);
  end

  // A pending leak blocks new events in IDLE so it is serviced first.
  assign bus.in_ready = (state == REFRAC) || ((state == IDLE) && !leak_pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      leak_pend   <= 1'b0;
      op_sub      <= 1'b0;
      cnt         <= '0;
      rcnt        <= '0;
      bus.vmem    <= '0;
      bus.spike   <= 1'b0;
      bus.acc_a   <= '0;
      bus.acc_b   <= '0;
      bus.acc_cin <= 1'b0;
    end else begin
      bus.spike <= 1'b0;
      case (state)
        IDLE: begin
          if (leak_pend || (!bus.in_valid && bus.leak_tick)) begin
            // Extra leak_ticks arriving with a pending leak merge into it.
            bus.acc_a   <= bus.vmem;
            bus.acc_b   <= ~LEAK_V;
            bus.acc_cin <= 1'b1;
            op_sub      <= 1'b1;
            leak_pend   <= 1'b0;
            cnt         <= SETTLE_LD;
            state       <= SETTLE;
          end else if (bus.in_valid) begin
            bus.acc_a   <= bus.vmem;
            bus.acc_b   <= bus.weight;
            bus.acc_cin <= 1'b0;
            op_sub      <= 1'b0;
            cnt         <= SETTLE_LD;
            state       <= SETTLE;
            if (bus.leak_tick) leak_pend <= 1'b1;
          end
        end

        SETTLE: begin
          if (bus.leak_tick) leak_pend <= 1'b1;
          if (cnt == '0) begin
            if (op_sub) begin
              bus.vmem <= sub_res;
              state    <= IDLE;
            end else if (add_res >= THRESH_V) begin
              bus.spike <= 1'b1;
              bus.vmem  <= '0;
              rcnt      <= REFRAC_LD;
              state     <= REFRAC;
            end else begin
              bus.vmem <= add_res;
              state    <= IDLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        REFRAC: begin
          // Accepted events and leak_ticks are dropped here.
          if (rcnt == '0) state <= IDLE;
          else            rcnt  <= rcnt - 4'd1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_neuron_ctrl.sv
module tb_if_neuron_ctrl;

  localparam int S = 3;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  int   spikes;

  if_neuron_ctrl_if bus();
  if_neuron_ctrl_if bus_hi();

  // External 10-bit adders seen by each controller.
  assign {bus.cout_in, bus.sum_in} =
    {1'b0, bus.acc_a} + {1'b0, bus.acc_b} + {10'd0, bus.acc_cin};
  assign {bus_hi.cout_in, bus_hi.sum_in} =
    {1'b0, bus_hi.acc_a} + {1'b0, bus_hi.acc_b} + {10'd0, bus_hi.acc_cin};

  if_neuron_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  if_neuron_ctrl #(.THRESH(1023)) u_dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus_hi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Present one event, then wait until its capture edge.
  task automatic run_event(input logic [9:0] w);
    bus.in_valid = 1'b1;
    bus.weight   = w;
    step();
    bus.in_valid = 1'b0;
    repeat (S) step();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    spikes = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.weight = '0;
    bus.leak_tick = 1'b0;
    bus_hi.in_valid = 1'b0;
    bus_hi.weight = '0;
    bus_hi.leak_tick = 1'b0;

    // Reset
    step();
    step();
    check("rst_vmem", bus.vmem, 0);
    check("rst_spike", bus.spike, 0);
    check("rst_acc_a", bus.acc_a, 0);
    check("rst_acc_b", bus.acc_b, 0);
    check("rst_acc_cin", bus.acc_cin, 0);
    rst = 1'b0;
    step();
    check("rst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.spike) spikes++;
    end
    check("idle_no_spike", spikes, 0);

    // Accumulate 100 then 200
    bus.in_valid = 1'b1;
    bus.weight = 10'd100;
    step();
    bus.in_valid = 1'b0;
    check("acc1_a", bus.acc_a, 0);
    check("acc1_b", bus.acc_b, 100);
    check("acc1_cin", bus.acc_cin, 0);
    check("acc1_busy", bus.in_ready, 0);
    step();
    check("acc1_b_hold1", bus.acc_b, 100);
    step();
    check("acc1_b_hold2", bus.acc_b, 100);
    check("acc1_vmem_early", bus.vmem, 0);
    step();
    check("acc1_vmem", bus.vmem, 100);
    check("acc1_spike", bus.spike, 0);
    check("acc1_ready", bus.in_ready, 1);
    run_event(10'd200);
    check("acc2_vmem", bus.vmem, 300);
    check("acc2_spike", bus.spike, 0);

    // Fire at 550, refractory behaviour
    run_event(10'd250);
    check("fire_spike", bus.spike, 1);
    check("fire_vmem", bus.vmem, 0);
    step();
    check("fire_spike_once", bus.spike, 0);
    bus.in_valid = 1'b1;
    bus.weight = 10'd50;
    step();
    bus.in_valid = 1'b0;
    bus.leak_tick = 1'b1;
    step();
    bus.leak_tick = 1'b0;
    check("refrac_discard", bus.vmem, 0);
    bus.in_valid = 1'b1;
    bus.weight = 10'd7;
    step();
    check("refrac_no_leak_pend", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("post_refrac_accept", bus.in_ready, 0);
    step();
    step();
    check("post_refrac_early", bus.vmem, 0);
    step();
    check("post_refrac_vmem", bus.vmem, 7);

    // Leak from 5
    do_reset();
    run_event(10'd5);
    check("leak_pre", bus.vmem, 5);
    bus.leak_tick = 1'b1;
    step();
    bus.leak_tick = 1'b0;
    check("leak_acc_a", bus.acc_a, 5);
    check("leak_acc_b", bus.acc_b, 1022);
    check("leak_acc_cin", bus.acc_cin, 1);
    check("leak_busy", bus.in_ready, 0);
    step();
    step();
    check("leak_vmem_early", bus.vmem, 5);
    step();
    check("leak_vmem", bus.vmem, 4);
    check("leak_no_spike", bus.spike, 0);

    // Leak from 0 clamps
    do_reset();
    bus.leak_tick = 1'b1;
    step();
    bus.leak_tick = 1'b0;
    repeat (S) step();
    check("leak_clamp", bus.vmem, 0);

    // Event and leak together, extra ticks merged
    do_reset();
    bus.in_valid = 1'b1;
    bus.weight = 10'd10;
    bus.leak_tick = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("sim_busy", bus.in_ready, 0);
    step();
    step();
    bus.leak_tick = 1'b0;
    step();
    check("sim_vmem_add", bus.vmem, 10);
    check("sim_pend_ready", bus.in_ready, 0);
    step();
    check("sim_leak_b", bus.acc_b, 1022);
    check("sim_leak_a", bus.acc_a, 10);
    repeat (S) step();
    check("sim_vmem_leak", bus.vmem, 9);
    check("sim_ready", bus.in_ready, 1);
    repeat (4) step();
    check("sim_merged", bus.vmem, 9);

    // Reset in the middle of SETTLE
    bus.in_valid = 1'b1;
    bus.weight = 10'd20;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_vmem", bus.vmem, 0);
    check("midrst_acc_b", bus.acc_b, 0);
    check("midrst_ready", bus.in_ready, 1);
    repeat (S) step();
    check("midrst_no_capture", bus.vmem, 0);
    check("midrst_no_spike", bus.spike, 0);

    // Full-scale weight from 0 fires at THRESH=512
    run_event(10'd1023);
    check("full_w_spike", bus.spike, 1);
    check("full_w_vmem", bus.vmem, 0);

    // Saturation with THRESH=1023: 900 + 200 carries out
    bus_hi.in_valid = 1'b1;
    bus_hi.weight = 10'd900;
    step();
    bus_hi.in_valid = 1'b0;
    repeat (S) step();
    check("hi_vmem_900", bus_hi.vmem, 900);
    check("hi_no_spike", bus_hi.spike, 0);
    bus_hi.in_valid = 1'b1;
    bus_hi.weight = 10'd200;
    step();
    bus_hi.in_valid = 1'b0;
    repeat (S) step();
    check("hi_sat_spike", bus_hi.spike, 1);
    check("hi_sat_vmem", bus_hi.vmem, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
